load_store_unit: RTL and testbench

Multi-cycle load/store unit between the execute stage and the register file write port of the RV32I core. It captures an effective address, store data and destination register from execute, and runs one request/ready transaction on the data-memory bus. It performs RV32I byte/halfword lane alignment and sign/zero extension. Load results are delivered as a one-cycle `RegWrite`/`rd`/`WD3` write, and `busy` stalls the rest of the core while the access is in flight.

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: captures one memory op from execute, runs a single
// request/ready bus transaction, and returns aligned, extended load data.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [31:0]           WriteData,
    input  logic [4:0]            rd_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic                  RegWrite,
    output logic [4:0]            rd,
    output logic [31:0]           WD3,
    output logic                  busy,
    output logic                  fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        illegal, misaligned, op_ok, load_done;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode of the op being offered by execute this cycle
    always_comb begin
        if (MemWrite)
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        else
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                     ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
        op_ok = start && !illegal && !misaligned;
    end

    // Store lane placement; loads always read the full word
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = WriteData;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << ALUResult[1:0];
                    wdata_nxt = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    be_nxt    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{WriteData[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = WriteData;
                end
            endcase
        end
    end

    // Load result extraction from the returned word using the captured offset
    always_comb begin
        byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    assign load_done = (state == REQ) && mem_ready && !is_store_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_ok) state_nxt = REQ;
            REQ:     if (mem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ);
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
            RegWrite   <= 1'b0;
            rd         <= 5'd0;
            WD3        <= 32'd0;
            fault      <= 1'b0;
        end else begin
            fault    <= (state == IDLE) && start && (illegal || misaligned);
            RegWrite <= load_done && (rd_q != 5'd0);
            if ((state == IDLE) && start) begin
                is_store_q <= MemWrite;
                funct3_q   <= funct3;
                off_q      <= ALUResult[1:0];
                rd_q       <= rd_in;
            end
            // Bus fields are loaded once and stay stable for the whole REQ
            if ((state == IDLE) && op_ok) begin
                mem_we    <= MemWrite;
                mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                mem_be    <= be_nxt;
                mem_wdata <= wdata_nxt;
            end
            if (load_done) begin
                rd  <= rd_q;
                WD3 <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, reset abort and
// ignored inputs, each checked against hand-computed values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, WriteData;
    logic [4:0]  rd_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WD3;
    logic        busy, fault;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .RegWrite(RegWrite),
        .rd(rd), .WD3(WD3), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic mw, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] r);
        start = 1'b1; MemWrite = mw; funct3 = f3; ALUResult = addr;
        WriteData = wd; rd_in = r;
    endtask

    // One full access: issue, hold REQ for `waits` cycles, complete, then IDLE
    task automatic run_op(input string tag, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] r, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic exp_rw, input logic [31:0] exp_wd3);
        issue(mw, f3, addr, wd, r);
        tick();
        start = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            check({tag, " mem_req"}, mem_req, 1'b1);
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " mem_addr"}, mem_addr, exp_addr);
            check({tag, " mem_be"}, mem_be, exp_be);
            check({tag, " mem_we"}, mem_we, mw);
            if (mw) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, " RegWrite early"}, RegWrite, 1'b0);
            mem_ready = (i == waits);
            mem_rdata = (i == waits) ? rdata : 32'h5A5A5A5A;
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check({tag, " done RegWrite"}, RegWrite, exp_rw);
        check({tag, " done busy"}, busy, 1'b1);
        check({tag, " done mem_req"}, mem_req, 1'b0);
        if (exp_rw) begin
            check({tag, " rd"}, rd, r);
            check({tag, " WD3"}, WD3, exp_wd3);
        end
        tick();
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle RegWrite"}, RegWrite, 1'b0);
    endtask

    task automatic run_fault(input string tag, input logic mw, input logic [2:0] f3,
                             input logic [31:0] addr);
        issue(mw, f3, addr, 32'hFFFF_FFFF, 5'd3);
        tick();
        start = 1'b0;
        check({tag, " fault"}, fault, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " mem_req"}, mem_req, 1'b0);
        tick();
        check({tag, " fault drop"}, fault, 1'b0);
        check({tag, " mem_req after"}, mem_req, 1'b0);
        check({tag, " busy after"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
        ALUResult = 32'd0; WriteData = 32'd0; rd_in = 5'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        check("rst mem_req", mem_req, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst RegWrite", RegWrite, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst fault", fault, 1'b0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst mem_be", mem_be, 4'b0000);
        check("rst WD3", WD3, 32'd0);
        check("rst rd", rd, 5'd0);
        rst = 1'b0;
        tick();

        run_op("LW", 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF,
               32'h100, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF);
        run_op("LB", 1'b0, 3'b000, 32'h203, 32'h0, 5'd6, 3, 32'h80112233,
               32'h200, 4'b1111, 32'h0, 1'b1, 32'hFFFFFF80);
        run_op("LBU", 1'b0, 3'b100, 32'h203, 32'h0, 5'd6, 3, 32'h80112233,
               32'h200, 4'b1111, 32'h0, 1'b1, 32'h00000080);
        run_op("LH hi", 1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 1, 32'h80011234,
               32'h100, 4'b1111, 32'h0, 1'b1, 32'hFFFF8001);
        run_op("LHU lo", 1'b0, 3'b101, 32'h100, 32'h0, 5'd8, 0, 32'h8001F234,
               32'h100, 4'b1111, 32'h0, 1'b1, 32'h0000F234);
        run_op("LB lane1", 1'b0, 3'b000, 32'h301, 32'h0, 5'd9, 0, 32'hAA7F55CC,
               32'h300, 4'b1111, 32'h0, 1'b1, 32'h00000055);
        run_op("SH", 1'b1, 3'b001, 32'h42, 32'h1234ABCD, 5'd0, 1, 32'h0,
               32'h40, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0);
        run_op("SB", 1'b1, 3'b000, 32'h61, 32'hCAFE0077, 5'd0, 0, 32'h0,
               32'h60, 4'b0010, 32'h77777777, 1'b0, 32'h0);
        run_op("SW", 1'b1, 3'b010, 32'h84, 32'h01234567, 5'd4, 2, 32'h0,
               32'h84, 4'b1111, 32'h01234567, 1'b0, 32'h0);
        run_op("LW rd0", 1'b0, 3'b010, 32'h10, 32'h0, 5'd0, 0, 32'h12345678,
               32'h10, 4'b1111, 32'h0, 1'b0, 32'h0);

        run_fault("LW mis", 1'b0, 3'b010, 32'h102);
        run_fault("LH mis", 1'b0, 3'b001, 32'h101);
        run_fault("L f3=011", 1'b0, 3'b011, 32'h100);
        run_fault("S f3=100", 1'b1, 3'b100, 32'h100);

        // A new start is accepted in the cycle the fault pulse is visible
        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd3);
        tick();
        issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd11);
        check("fault b2b fault", fault, 1'b1);
        tick();
        start = 1'b0;
        check("fault b2b mem_req", mem_req, 1'b1);
        check("fault b2b addr", mem_addr, 32'h104);
        check("fault b2b fault drop", fault, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        tick();
        mem_ready = 1'b0;
        check("fault b2b RegWrite", RegWrite, 1'b1);
        check("fault b2b WD3", WD3, 32'hA5A50001);
        tick();

        // Reset in cycle 2 of a stalled load aborts it
        issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd12);
        tick();
        start = 1'b0;
        check("abort c1 mem_req", mem_req, 1'b1);
        tick();
        check("abort c2 mem_req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort c3 mem_req", mem_req, 1'b0);
        check("abort c3 busy", busy, 1'b0);
        check("abort c3 RegWrite", RegWrite, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        check("abort c4 RegWrite", RegWrite, 1'b0);
        check("ready idle busy", busy, 1'b0);
        mem_ready = 1'b0;
        tick();
        check("ready idle RegWrite", RegWrite, 1'b0);

        // A start pulse during REQ must not disturb the access in flight
        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
        tick();
        issue(1'b1, 3'b010, 32'h400, 32'h0, 5'd10);
        check("ign c1 addr", mem_addr, 32'h300);
        tick();
        start = 1'b0;
        check("ign c2 addr", mem_addr, 32'h300);
        check("ign c2 we", mem_we, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'h00000011;
        tick();
        mem_ready = 1'b0;
        check("ign RegWrite", RegWrite, 1'b1);
        check("ign rd", rd, 5'd9);
        check("ign WD3", WD3, 32'h11);
        tick();
        check("ign idle busy", busy, 1'b0);
        check("ign idle mem_req", mem_req, 1'b0);
        check("ign rd held", rd, 5'd9);
        check("ign WD3 held", WD3, 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
